// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants, types and helpers for the serial pattern detector
package seq_det_pkg;

    localparam int unsigned DEF_PAT_W = 8;
    localparam int unsigned DEF_CNT_W = 8;
    localparam int unsigned DEF_LEN_W = $clog2(DEF_PAT_W + 1);

    // Active configuration at the default pattern width.
    typedef struct packed {
        logic [DEF_PAT_W-1:0] pat;
        logic [DEF_LEN_W-1:0] len;
    } cfg_t;

    // Zero or over-long lengths fall back to the full pattern width.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len == 0 || len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with priority clear
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && cnt_o != '1) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - programmable serial bit-pattern detector with match counter
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter  int unsigned PAT_W = DEF_PAT_W,
    parameter  int unsigned CNT_W = DEF_CNT_W,
    localparam int unsigned LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             valid_i,
    input  logic             data_i,
    input  logic             cfg_we_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [LEN_W-1:0] pat_len_i,
    input  logic             overlap_i,
    input  logic             cnt_clr_i,
    output logic             match_o,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic [PAT_W-1:0] cfg_pat_o,
    output logic [LEN_W-1:0] cfg_len_o
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] hist_next;
    logic [PAT_W-1:0] len_mask;
    logic [LEN_W-1:0] fill;
    logic [LEN_W-1:0] fill_next;
    logic             accept;
    logic             hit;
    logic             match;

    // A config write takes precedence over a bit arriving in the same cycle.
    always_comb begin
        accept    = valid_i && !cfg_we_i;
        hist_next = {hist[PAT_W-2:0], data_i};
        fill_next = (fill == LEN_MAX) ? LEN_MAX : fill + 1'b1;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (LEN_W'(i) < cfg_len);
        end
        hit = accept && (fill_next >= cfg_len) && (((hist_next ^ cfg_pat) & len_mask) == '0);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cfg_pat <= '0;
            cfg_len <= LEN_MAX;
            hist    <= '0;
            fill    <= '0;
            match   <= 1'b0;
        end else begin
            match <= hit;
            if (cfg_we_i) begin
                cfg_pat <= pattern_i;
                cfg_len <= LEN_W'(clamp_len(32'(pat_len_i), PAT_W));
                hist    <= '0;
                fill    <= '0;
            end else if (accept) begin
                hist <= hist_next;
                // Non-overlap restarts the fill so the next match needs fresh bits.
                fill <= (hit && !overlap_i) ? '0 : fill_next;
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .inc_i  (hit),
        .clr_i  (cnt_clr_i),
        .cnt_o  (match_cnt_o)
    );

    assign match_o   = match;
    assign cfg_pat_o = cfg_pat;
    assign cfg_len_o = cfg_len;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - directed self-checking bench for seq_pattern_detector
module tb_seq_pattern_detector;

    localparam int PAT_W = 8;
    localparam int CNT_W = 2;
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic             valid_i;
    logic             data_i;
    logic             cfg_we_i;
    logic [PAT_W-1:0] pattern_i;
    logic [LEN_W-1:0] pat_len_i;
    logic             overlap_i;
    logic             cnt_clr_i;
    logic             match_o;
    logic [CNT_W-1:0] match_cnt_o;
    logic [PAT_W-1:0] cfg_pat_o;
    logic [LEN_W-1:0] cfg_len_o;

    int n_vec = 0;
    int n_bad = 0;

    seq_pattern_detector #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .cfg_we_i   (cfg_we_i),
        .pattern_i  (pattern_i),
        .pat_len_i  (pat_len_i),
        .overlap_i  (overlap_i),
        .cnt_clr_i  (cnt_clr_i),
        .match_o    (match_o),
        .match_cnt_o(match_cnt_o),
        .cfg_pat_o  (cfg_pat_o),
        .cfg_len_o  (cfg_len_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i   = 1'b0;
        data_i    = 1'b0;
        cfg_we_i  = 1'b0;
        cnt_clr_i = 1'b0;
    endtask

    task automatic load_cfg(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len, input logic clr);
        idle_inputs();
        cfg_we_i  = 1'b1;
        pattern_i = pat;
        pat_len_i = len;
        cnt_clr_i = clr;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        reset_i   = 1'b0;
        valid_i   = 1'b1;
        data_i    = 1'b1;
        cfg_we_i  = 1'b1;
        pattern_i = 8'hFF;
        pat_len_i = 4'd3;
        overlap_i = 1'b1;
        cnt_clr_i = 1'b0;
        tick();
        tick();
        n_vec++; if (match_o !== 1'b0) begin n_bad++; $display("FAIL reset_match got %b want 0", match_o); end
        n_vec++; if (match_cnt_o !== 2'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", match_cnt_o); end
        n_vec++; if (cfg_len_o !== 4'd8) begin n_bad++; $display("FAIL reset_len got %0d want 8", cfg_len_o); end
        n_vec++; if (cfg_pat_o !== 8'h00) begin n_bad++; $display("FAIL reset_pat got %h want 00", cfg_pat_o); end
        idle_inputs();
        reset_i = 1'b1;
        tick();
    endtask

    task automatic test_overlap();
        int bits[5] = '{1, 0, 1, 0, 1};
        int em[5]   = '{0, 0, 1, 0, 1};
        int ec[5]   = '{0, 0, 1, 1, 2};
        overlap_i = 1'b1;
        load_cfg(8'b0000_0101, 4'd3, 1'b1);
        n_vec++; if (cfg_pat_o !== 8'h05) begin n_bad++; $display("FAIL ovl_cfg_pat got %h want 05", cfg_pat_o); end
        n_vec++; if (cfg_len_o !== 4'd3) begin n_bad++; $display("FAIL ovl_cfg_len got %0d want 3", cfg_len_o); end
        n_vec++; if (match_o !== 1'b0) begin n_bad++; $display("FAIL ovl_cfg_match got %b want 0", match_o); end
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1;
            data_i  = 1'(bits[i]);
            tick();
            n_vec++; if (match_o !== 1'(em[i])) begin n_bad++; $display("FAIL ovl_match[%0d] got %b want %0d", i, match_o, em[i]); end
            n_vec++; if (match_cnt_o !== 2'(ec[i])) begin n_bad++; $display("FAIL ovl_cnt[%0d] got %0d want %0d", i, match_cnt_o, ec[i]); end
        end
        idle_inputs();
        tick();
        n_vec++; if (match_o !== 1'b0) begin n_bad++; $display("FAIL ovl_idle_match got %b want 0", match_o); end
    endtask

    task automatic test_nonoverlap();
        int bits[5] = '{1, 0, 1, 0, 1};
        int em[5]   = '{0, 0, 1, 0, 0};
        int ec[5]   = '{0, 0, 1, 1, 1};
        overlap_i = 1'b0;
        load_cfg(8'b0000_0101, 4'd3, 1'b1);
        n_vec++; if (match_cnt_o !== 2'd0) begin n_bad++; $display("FAIL novl_clr got %0d want 0", match_cnt_o); end
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1;
            data_i  = 1'(bits[i]);
            tick();
            n_vec++; if (match_o !== 1'(em[i])) begin n_bad++; $display("FAIL novl_match[%0d] got %b want %0d", i, match_o, em[i]); end
            n_vec++; if (match_cnt_o !== 2'(ec[i])) begin n_bad++; $display("FAIL novl_cnt[%0d] got %0d want %0d", i, match_cnt_o, ec[i]); end
        end
        idle_inputs();
    endtask

    task automatic test_valid_gaps();
        int bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        int gap;
        overlap_i = 1'b1;
        load_cfg(8'hA5, 4'd8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                valid_i = 1'b0;
                data_i  = 1'($urandom_range(0, 1));
                tick();
                n_vec++; if (match_o !== 1'b0) begin n_bad++; $display("FAIL gap_match[%0d.%0d] got %b want 0", i, g, match_o); end
            end
            valid_i = 1'b1;
            data_i  = 1'(bits[i]);
            tick();
            n_vec++; if (match_o !== (i == 7)) begin n_bad++; $display("FAIL gap_bit_match[%0d] got %b want %0d", i, match_o, (i == 7)); end
        end
        valid_i = 1'b0;
        data_i  = 1'b1;
        tick();
        n_vec++; if (match_o !== 1'b0) begin n_bad++; $display("FAIL gap_after_match got %b want 0", match_o); end
        n_vec++; if (match_cnt_o !== 2'd1) begin n_bad++; $display("FAIL gap_cnt got %0d want 1", match_cnt_o); end
        idle_inputs();
    endtask

    task automatic test_reconfig();
        overlap_i = 1'b1;
        load_cfg(8'b0000_0101, 4'd3, 1'b1);
        valid_i = 1'b1; data_i = 1'b1; tick();
        valid_i = 1'b1; data_i = 1'b0; tick();
        cfg_we_i  = 1'b1;
        pattern_i = 8'b0000_0011;
        pat_len_i = 4'd2;
        valid_i   = 1'b1;
        data_i    = 1'b1;
        tick();
        cfg_we_i = 1'b0;
        n_vec++; if (match_o !== 1'b0) begin n_bad++; $display("FAIL rcfg_load_match got %b want 0", match_o); end
        n_vec++; if (cfg_len_o !== 4'd2) begin n_bad++; $display("FAIL rcfg_len got %0d want 2", cfg_len_o); end
        n_vec++; if (cfg_pat_o !== 8'h03) begin n_bad++; $display("FAIL rcfg_pat got %h want 03", cfg_pat_o); end
        valid_i = 1'b1; data_i = 1'b1; tick();
        n_vec++; if (match_o !== 1'b0) begin n_bad++; $display("FAIL rcfg_first1 got %b want 0", match_o); end
        valid_i = 1'b1; data_i = 1'b1; tick();
        n_vec++; if (match_o !== 1'b1) begin n_bad++; $display("FAIL rcfg_second1 got %b want 1", match_o); end
        n_vec++; if (match_cnt_o !== 2'd1) begin n_bad++; $display("FAIL rcfg_cnt got %0d want 1", match_cnt_o); end
        idle_inputs();
        load_cfg(8'h00, 4'd0, 1'b0);
        n_vec++; if (cfg_len_o !== 4'd8) begin n_bad++; $display("FAIL clamp_zero got %0d want 8", cfg_len_o); end
        load_cfg(8'h00, 4'd9, 1'b0);
        n_vec++; if (cfg_len_o !== 4'd8) begin n_bad++; $display("FAIL clamp_nine got %0d want 8", cfg_len_o); end
    endtask

    task automatic test_saturation();
        int ec[6] = '{1, 2, 3, 3, 3, 3};
        overlap_i = 1'b1;
        load_cfg(8'b1111_1101, 4'd1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            valid_i = 1'b1;
            data_i  = 1'b1;
            tick();
            n_vec++; if (match_o !== 1'b1) begin n_bad++; $display("FAIL sat_match[%0d] got %b want 1", i, match_o); end
            n_vec++; if (match_cnt_o !== 2'(ec[i])) begin n_bad++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, match_cnt_o, ec[i]); end
        end
        valid_i = 1'b1; data_i = 1'b0; tick();
        n_vec++; if (match_o !== 1'b0) begin n_bad++; $display("FAIL len1_zero got %b want 0", match_o); end
        valid_i = 1'b0; data_i = 1'b1; tick();
        n_vec++; if (match_o !== 1'b0) begin n_bad++; $display("FAIL sat_novalid got %b want 0", match_o); end
        n_vec++; if (match_cnt_o !== 2'd3) begin n_bad++; $display("FAIL sat_hold got %0d want 3", match_cnt_o); end
        valid_i = 1'b1; data_i = 1'b1; cnt_clr_i = 1'b1; tick();
        cnt_clr_i = 1'b0;
        n_vec++; if (match_o !== 1'b1) begin n_bad++; $display("FAIL clr_match got %b want 1", match_o); end
        n_vec++; if (match_cnt_o !== 2'd0) begin n_bad++; $display("FAIL clr_cnt got %0d want 0", match_cnt_o); end
        valid_i = 1'b1; data_i = 1'b1; tick();
        n_vec++; if (match_cnt_o !== 2'd1) begin n_bad++; $display("FAIL clr_recount got %0d want 1", match_cnt_o); end
        reset_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 1'b1;
        tick();
        n_vec++; if (match_o !== 1'b0) begin n_bad++; $display("FAIL mrst_match got %b want 0", match_o); end
        n_vec++; if (match_cnt_o !== 2'd0) begin n_bad++; $display("FAIL mrst_cnt got %0d want 0", match_cnt_o); end
        n_vec++; if (cfg_pat_o !== 8'h00) begin n_bad++; $display("FAIL mrst_pat got %h want 00", cfg_pat_o); end
        n_vec++; if (cfg_len_o !== 4'd8) begin n_bad++; $display("FAIL mrst_len got %0d want 8", cfg_len_o); end
        reset_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            valid_i = 1'b1;
            data_i  = 1'b0;
            tick();
            n_vec++; if (match_o !== (i == 7)) begin n_bad++; $display("FAIL mrst_fill[%0d] got %b want %0d", i, match_o, (i == 7)); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_valid_gaps();
        test_reconfig();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
